// File: rtl/hp48_rom_slave_pkg.sv
// Shared HP48 nibble-bus definitions: command codes, widths and window helpers.
package hp48_rom_slave_pkg;

   localparam int unsigned AddrW = 20;
   localparam int unsigned NibW  = 4;

   typedef enum logic [3:0] {
      CmdNop         = 4'd0,
      CmdPcRead      = 4'd1,
      CmdDpRead      = 4'd2,
      CmdDpWrite     = 4'd3,
      CmdLoadPc      = 4'd4,
      CmdLoadDp      = 4'd5,
      CmdConfigure   = 4'd6,
      CmdUnconfigure = 4'd7,
      CmdReset       = 4'd8
   } bus_cmd_e;

   // Mask of the address bits that select the window (bits at or above size_log2).
   function automatic logic [AddrW-1:0] window_mask(input int unsigned size_log2);
      logic [AddrW-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < AddrW; i++) begin
         if (i >= size_log2) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic in_window(input logic [AddrW-1:0] addr,
                                      input logic [AddrW-1:0] base,
                                      input logic [AddrW-1:0] mask);
      return ((addr ^ base) & mask) == '0;
   endfunction

endpackage

// File: rtl/hp48_bus_ptr.sv
// Saturn bus pointer (PC or DP): load, clear, increment with 20-bit wrap, window hit/offset.
module hp48_bus_ptr
   import hp48_rom_slave_pkg::*;
#(
   parameter int unsigned SIZE_LOG2 = 19
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 load,
   input  logic                 incr,
   input  logic [AddrW-1:0]     load_value,
   input  logic [AddrW-1:0]     base,
   input  logic                 configured,
   output logic [AddrW-1:0]     ptr,
   output logic                 hit,
   output logic [SIZE_LOG2-1:0] offset
);

   localparam logic [AddrW-1:0] WinMask = window_mask(SIZE_LOG2);

   logic [AddrW-1:0] ptr_d, ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (clear) begin
         ptr_d = '0;
      end else if (load) begin
         ptr_d = load_value;
      end else if (incr) begin
         ptr_d = ptr_q + 20'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr    = ptr_q;
   assign hit    = configured && in_window(ptr_q, base, WinMask);
   assign offset = ptr_q[SIZE_LOG2-1:0];

endmodule

// File: rtl/hp48_rom_slave.sv
// HP48 nibble-bus memory slave: PC/DP pointers, window decode, 2-cycle read return.
// Define HP48_ROM_WRITE_EN to let DP_WRITE hits reach memory; otherwise writes fault.
module hp48_rom_slave
   import hp48_rom_slave_pkg::*;
#(
   parameter logic [AddrW-1:0] BASE      = 20'h00000,
   parameter int unsigned      SIZE_LOG2 = 19,
   parameter bit               FIXED     = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 strobe,
   input  logic [3:0]           command,
   input  logic [AddrW-1:0]     address,
   input  logic [NibW-1:0]      nibble_in,
   output logic [NibW-1:0]      nibble_out,
   output logic                 nibble_valid,
   output logic                 bus_error,
   output logic                 write_fault,
   output logic                 configured,
   output logic [AddrW-1:0]     pc_ptr,
   output logic [SIZE_LOG2-1:0] mem_addr,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [NibW-1:0]      mem_wdata,
   input  logic [NibW-1:0]      mem_rdata
);

   localparam logic [AddrW-1:0] WinMask = window_mask(SIZE_LOG2);

   bus_cmd_e cmd;
   assign cmd = bus_cmd_e'(command);

   logic [AddrW-1:0]     base_d, base_q;
   logic                 configured_d, configured_q;
   logic                 rd_d, rd_q, wr_d, wr_q;
   logic [SIZE_LOG2-1:0] addr_d, addr_q;
   logic [NibW-1:0]      wdata_d, wdata_q;
   logic                 bus_error_d, bus_error_q;
   logic                 write_fault_d, write_fault_q;
   logic                 valid_q;
   logic [NibW-1:0]      hold_q;

   logic                 ptr_clear, pc_load, pc_incr, dp_load, dp_incr;
   logic                 pc_hit, dp_hit;
   logic [SIZE_LOG2-1:0] pc_offset, dp_offset;
   logic [AddrW-1:0]     dp_ptr;

   hp48_bus_ptr #(
      .SIZE_LOG2 (SIZE_LOG2)
   ) u_pc (
      .clk        (clk),
      .reset      (reset),
      .clear      (ptr_clear),
      .load       (pc_load),
      .incr       (pc_incr),
      .load_value (address),
      .base       (base_q),
      .configured (configured_q),
      .ptr        (pc_ptr),
      .hit        (pc_hit),
      .offset     (pc_offset)
   );

   hp48_bus_ptr #(
      .SIZE_LOG2 (SIZE_LOG2)
   ) u_dp (
      .clk        (clk),
      .reset      (reset),
      .clear      (ptr_clear),
      .load       (dp_load),
      .incr       (dp_incr),
      .load_value (address),
      .base       (base_q),
      .configured (configured_q),
      .ptr        (dp_ptr),
      .hit        (dp_hit),
      .offset     (dp_offset)
   );

   // DP value is only consumed through its hit/offset decode.
   logic unused_dp;
   assign unused_dp = ^dp_ptr;

   always_comb begin
      ptr_clear     = 1'b0;
      pc_load       = 1'b0;
      pc_incr       = 1'b0;
      dp_load       = 1'b0;
      dp_incr       = 1'b0;
      base_d        = base_q;
      configured_d  = configured_q;
      rd_d          = 1'b0;
      wr_d          = 1'b0;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      bus_error_d   = 1'b0;
      write_fault_d = 1'b0;
      if (strobe) begin
         case (cmd)
            CmdNop: ;
            CmdPcRead: begin
               pc_incr = 1'b1;
               if (pc_hit) begin
                  rd_d   = 1'b1;
                  addr_d = pc_offset;
               end
            end
            CmdDpRead: begin
               dp_incr = 1'b1;
               if (dp_hit) begin
                  rd_d   = 1'b1;
                  addr_d = dp_offset;
               end
            end
            CmdDpWrite: begin
               dp_incr = 1'b1;
               // Address/data track the attempted write even when it faults.
               if (dp_hit) begin
                  addr_d  = dp_offset;
                  wdata_d = nibble_in;
`ifdef HP48_ROM_WRITE_EN
                  wr_d          = 1'b1;
`else
                  write_fault_d = 1'b1;
`endif
               end
            end
            CmdLoadPc: pc_load = 1'b1;
            CmdLoadDp: dp_load = 1'b1;
            CmdConfigure: begin
               if (!FIXED && !configured_q) begin
                  base_d       = address & WinMask;
                  configured_d = 1'b1;
               end
            end
            CmdUnconfigure: begin
               if (!FIXED && configured_q && in_window(address, base_q, WinMask)) begin
                  configured_d = 1'b0;
               end
            end
            CmdReset: begin
               ptr_clear    = 1'b1;
               configured_d = FIXED;
            end
            default: bus_error_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         base_q        <= BASE & WinMask;
         configured_q  <= FIXED;
         rd_q          <= 1'b0;
         wr_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         bus_error_q   <= 1'b0;
         write_fault_q <= 1'b0;
         valid_q       <= 1'b0;
         hold_q        <= '0;
      end else begin
         base_q        <= base_d;
         configured_q  <= configured_d;
         rd_q          <= rd_d;
         wr_q          <= wr_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         bus_error_q   <= bus_error_d;
         write_fault_q <= write_fault_d;
         valid_q       <= rd_q;
         if (valid_q) hold_q <= mem_rdata;
      end
   end

   // Memory data arrives in the return cycle; it is forwarded then and held afterwards.
   assign nibble_out   = valid_q ? mem_rdata : hold_q;
   assign nibble_valid = valid_q;
   assign bus_error    = bus_error_q;
   assign write_fault  = write_fault_q;
   assign configured   = configured_q;
   assign mem_addr     = addr_q;
   assign mem_rd       = rd_q;
   assign mem_wr       = wr_q;
   assign mem_wdata    = wdata_q;

endmodule
